// File: rtl/lut_layer_sched.sv
// Time-multiplexed LogicNets layer: one shared LUT lookup path walks all neurons
// of the layer, one neuron per cycle, against a captured input feature vector.
module lut_layer_sched #(
    parameter int IN_WIDTH  = 128,
    parameter int N_NEURONS = 128,
    parameter int FANIN     = 6,
    parameter int IDXW      = 7,
    parameter int NW        = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_WIDTH-1:0]   s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [N_NEURONS-1:0]  m_data,
    input  logic                  cfg_we,
    input  logic [NW-1:0]         cfg_addr,
    input  logic [(1<<FANIN)-1:0] cfg_table,
    input  logic [FANIN*IDXW-1:0] cfg_idx,
    output logic                  cfg_ready,
    output logic                  cfg_drop,
    output logic                  busy
);

    localparam int TW = 1 << FANIN;
    localparam int AW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [IN_WIDTH-1:0]   vec;
    logic [AW:0]           fcnt;
    logic                  pv;
    logic [AW-1:0]         pidx;
    logic [TW-1:0]         ptable;
    logic [FANIN*IDXW-1:0] pidxs;
    logic [FANIN-1:0]      addr;
    logic                  cfgHit;

    logic [TW-1:0]         tblMem [N_NEURONS];
    logic [FANIN*IDXW-1:0] idxMem [N_NEURONS];

    assign cfgHit = cfg_we && (state == IDLE) && (int'(cfg_addr) < N_NEURONS);

    // Gather the lookup address; indices past the vector width read as 0
    always_comb begin
        addr = '0;
        for (int k = 0; k < FANIN; k++) begin
            if (int'(pidxs[k*IDXW +: IDXW]) < IN_WIDTH)
                addr[k] = vec[pidxs[k*IDXW +: IDXW]];
        end
    end

    always_ff @(posedge clk) begin
        if (cfgHit) begin
            tblMem[cfg_addr[AW-1:0]] <= cfg_table;
            idxMem[cfg_addr[AW-1:0]] <= cfg_idx;
        end
    end

    // Two-stage walk: fetch neuron fcnt from memory, then evaluate the fetched
    // neuron one cycle later, so same-edge config writes are always visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_ready   <= 1'b1;
            cfg_ready <= 1'b1;
            m_valid   <= 1'b0;
            m_data    <= '0;
            cfg_drop  <= 1'b0;
            busy      <= 1'b0;
            fcnt      <= '0;
            pv        <= 1'b0;
            pidx      <= '0;
        end else begin
            if (cfg_we && !cfgHit)
                cfg_drop <= 1'b1;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        vec       <= s_data;
                        fcnt      <= '0;
                        pv        <= 1'b0;
                        state     <= RUN;
                        s_ready   <= 1'b0;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (int'(fcnt) < N_NEURONS) begin
                        ptable <= tblMem[fcnt[AW-1:0]];
                        pidxs  <= idxMem[fcnt[AW-1:0]];
                        pidx   <= fcnt[AW-1:0];
                        pv     <= 1'b1;
                        fcnt   <= fcnt + 1'b1;
                    end else begin
                        pv <= 1'b0;
                    end
                    if (pv) begin
                        m_data[pidx] <= ptable[addr];
                        if (int'(pidx) == N_NEURONS - 1) begin
                            state   <= DONE;
                            m_valid <= 1'b1;
                            pv      <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        state     <= IDLE;
                        m_valid   <= 1'b0;
                        s_ready   <= 1'b1;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
